fft_frame_ctrl: RTL and testbench

FFT_FRAME_CTRL -- requirements
Module: fft_frame_ctrl

---
 rtl/fft_frame_ctrl.sv | 93 +++++++++
 tb/tb_fft_frame_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl: stream framing controller for a bit-reversing FFT datapath.
//   Accepts a sample stream, zero-pads the final partial frame, drains one
//   extra frame to flush the buffer, then pulses a datapath reset.
// Ports:
//   i_clk, i_reset        clock; synchronous active-high reset
//   i_valid/o_ready       upstream handshake; i_data sample, i_last end of stream
//   o_dp_ce, o_dp_reset   datapath step enable and synchronous reset
//   o_dp_data             word written into the datapath on each o_dp_ce
//   i_dp_data, i_dp_sync  datapath output word and its frame-start flag
//   o_valid/i_ready       downstream handshake; o_data word, o_sync frame start,
//                         o_last final word of the stream
//   o_busy                high while a stream is in progress
module fft_frame_ctrl #(
   parameter int LGSIZE = 5,
   parameter int WIDTH  = 24
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_valid,
   output logic               o_ready,
   input  logic [2*WIDTH-1:0] i_data,
   input  logic               i_last,
   output logic               o_dp_ce,
   output logic               o_dp_reset,
   output logic [2*WIDTH-1:0] o_dp_data,
   input  logic [2*WIDTH-1:0] i_dp_data,
   input  logic               i_dp_sync,
   output logic               o_valid,
   input  logic               i_ready,
   output logic [2*WIDTH-1:0] o_data,
   output logic               o_sync,
   output logic               o_last,
   output logic               o_busy
);
   typedef enum logic [2:0] {IDLE, RUN, PAD, DRAIN, DONE, RST} state_t;
   state_t            r_state, w_next;
   logic [LGSIZE-1:0] r_wcnt;
   logic              r_primed, r_valid, r_last;
   logic              w_wrap, w_space, w_open, w_accept, w_ce;
   assign w_wrap   = &r_wcnt;
   // outputs are masked during reset so nothing in flight is presented
   assign o_valid  = r_valid && !i_reset;
   assign o_last   = r_last && !i_reset;
   assign w_space  = !o_valid || i_ready;
   assign w_open   = (r_state == IDLE) || (r_state == RUN);
   assign o_ready  = w_open && w_space && !i_reset;
   assign w_accept = i_valid && o_ready;
   // padding and drain steps advance only when the output slot can take a word
   assign w_ce       = w_accept || ((r_state == PAD || r_state == DRAIN) && w_space && !i_reset);
   assign o_dp_ce    = w_ce;
   assign o_dp_data  = w_accept ? i_data : '0;
   assign o_dp_reset = i_reset || (r_state == RST);
   assign o_data     = i_dp_data;
   assign o_sync     = i_dp_sync && o_valid;
   assign o_busy     = r_state != IDLE;
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE, RUN: if (w_accept) w_next = i_last ? (w_wrap ? DRAIN : PAD) : RUN;
         PAD:       if (w_ce && w_wrap) w_next = DRAIN;
         DRAIN:     if (w_ce && w_wrap) w_next = DONE;
         DONE:      if (!r_valid) w_next = RST;
         RST:       w_next = IDLE;
         default:   w_next = IDLE;
      endcase
   end
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state  <= IDLE;
         r_wcnt   <= '0;
         r_primed <= 1'b0;
         r_valid  <= 1'b0;
         r_last   <= 1'b0;
      end else begin
         r_state <= w_next;
         if (r_state == RST) begin
            r_wcnt   <= '0;
            r_primed <= 1'b0;
         end else if (w_ce) begin
            r_wcnt <= r_wcnt + 1'b1;
            // once a whole frame is written, every later step yields a real word
            if (w_wrap && (r_state == RUN || r_state == PAD)) r_primed <= 1'b1;
         end
         if (w_ce) begin
            r_valid <= r_primed;
            r_last  <= (r_state == DRAIN) && w_wrap;
         end else if (i_ready) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_fft_frame_ctrl.sv
// tb_fft_frame_ctrl: randomized self-checking bench with a bit-reverse datapath model.
module tb_fft_frame_ctrl;
   localparam int LG = 3;
   localparam int N  = 8;
   localparam int W  = 12;
   localparam int DW = 2 * W;
   logic clk = 1'b0;
   logic i_reset, i_valid, i_last, i_ready;
   logic [DW-1:0] i_data;
   logic o_ready, o_dp_ce, o_dp_reset, o_valid, o_sync, o_last, o_busy;
   logic [DW-1:0] o_dp_data, o_data, dp_data;
   logic dp_sync;
   int checks = 0;
   int errors = 0;
   logic [DW-1:0] samp [64];
   logic [DW-1:0] dp_mem [64];
   int dp_cnt = 0;
   int dp_j;
   int acc_cnt = 0, ce_cnt = 0, hold_err = 0, gap_err = 0, dpr_cnt = 0;
   bit gap = 1'b0;
   bit pv = 1'b0, prev_stall = 1'b0;
   logic [DW+1:0] prev_word, mon_cur;
   logic [DW+1:0] outq [$];
   int rise_q [$];
   always #5 clk = ~clk;
   fft_frame_ctrl #(.LGSIZE(LG), .WIDTH(W)) dut (
      .i_clk(clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
      .i_data(i_data), .i_last(i_last), .o_dp_ce(o_dp_ce), .o_dp_reset(o_dp_reset),
      .o_dp_data(o_dp_data), .i_dp_data(dp_data), .i_dp_sync(dp_sync),
      .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .o_sync(o_sync),
      .o_last(o_last), .o_busy(o_busy)
   );
   function automatic int bitrev(input int k);
      int r = 0;
      for (int i = 0; i < LG; i++) r = (r << 1) | ((k >> i) & 1);
      return r;
   endfunction
   // datapath: word k of frame f appears after ce number (f+1)*N+k+1
   always @(posedge clk) begin
      if (o_dp_reset) dp_cnt <= 0;
      else if (o_dp_ce) begin
         dp_mem[dp_cnt % 64] <= o_dp_data;
         dp_cnt <= dp_cnt + 1;
      end
   end
   always_comb begin
      dp_j = dp_cnt - N - 1;
      dp_data = '0;
      dp_sync = 1'b0;
      if (dp_j >= 0) begin
         dp_data = dp_mem[((dp_j / N) * N + bitrev(dp_j % N)) % 64];
         dp_sync = (dp_j % N) == 0;
      end
   end
   // expected output word j of an n-sample stream: {data, sync, last}
   function automatic logic [DW+1:0] exp_word(input int n, input int j);
      int f = j / N;
      int k = j % N;
      int idx = f * N + bitrev(k);
      int nf = (n + N - 1) / N;
      logic [DW-1:0] d = (idx < n) ? samp[idx] : '0;
      return {d, k == 0, (f == nf - 1) && (k == N - 1)};
   endfunction
   always @(negedge clk) begin
      mon_cur = {o_data, o_sync, o_last};
      if (prev_stall && (!o_valid || mon_cur !== prev_word)) hold_err++;
      if (o_valid && !i_ready && o_dp_ce) hold_err++;
      prev_stall = o_valid && !i_ready;
      prev_word = mon_cur;
      if (o_valid && !pv) rise_q.push_back(acc_cnt);
      pv = o_valid;
      if (o_valid && i_ready) outq.push_back(mon_cur);
      if (i_valid && o_ready) acc_cnt++;
      if (o_dp_ce) ce_cnt++;
      if (gap && o_dp_ce) gap_err++;
      if (o_dp_reset && !i_reset) dpr_cnt++;
   end
   // drives one stream from samp[]; starts and ends just after a rising edge
   task automatic drive(input int n, input int rmode, input int g1, input int g2, input int rst_at);
      int idx = 0, gcnt = 0, cyc = 0;
      bit done = 1'b0, acc;
      while (!done && cyc < 2000) begin
         i_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? (cyc % 2 == 0) : ($urandom_range(0, 3) != 0);
         gap = gcnt > 0;
         if (idx < n && gcnt == 0) begin
            i_valid = 1'b1;
            i_data  = samp[idx];
            i_last  = idx == n - 1;
         end else begin
            i_valid = (idx == n && o_busy) ? 1'(($urandom)) : 1'b0;
            i_data  = DW'($urandom);
            i_last  = 1'($urandom);
         end
         @(negedge clk);
         acc = i_valid && o_ready;
         @(posedge clk);
         #1;
         cyc++;
         if (gcnt > 0) gcnt--;
         if (acc) begin
            idx++;
            if (idx == g1 + 1 || idx == g2 + 1) gcnt = 3;
         end
         if (rst_at > 0 && idx == rst_at) begin
            gap = 1'b0;
            return;
         end
         if (idx == n && !o_busy) done = 1'b1;
      end
      gap = 1'b0;
      i_valid = 1'b0;
      i_ready = 1'b1;
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL stream_timeout: accepted %0d of %0d, busy %0b", idx, n, o_busy);
      end
   endtask
   task automatic test_reset();
      i_reset = 1'b1; i_valid = 1'b1; i_ready = 1'b1; i_last = 1'b0; i_data = DW'(7);
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", o_ready); end
      checks++; if (o_dp_ce !== 1'b0) begin errors++; $display("FAIL rst_ce: got %b want 0", o_dp_ce); end
      checks++; if (o_dp_reset !== 1'b1) begin errors++; $display("FAIL rst_dpreset: got %b want 1", o_dp_reset); end
      @(posedge clk);
      #1;
      i_reset = 1'b0; i_valid = 1'b0;
      #1;
      checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", o_valid); end
      checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", o_busy); end
      checks++; if (o_last !== 1'b0) begin errors++; $display("FAIL rst_last: got %b want 0", o_last); end
      checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL rst_idle_ready: got %b want 1", o_ready); end
   endtask
   task automatic test_continuous();
      int qb = outq.size(), ab = acc_cnt, rb = rise_q.size(), cb = ce_cnt, db = dpr_cnt, nw, rise;
      for (int i = 0; i < 16; i++) samp[i] = DW'(i);
      drive(16, 0, -1, -1, 0);
      nw = outq.size() - qb;
      checks++; if (nw != 16) begin errors++; $display("FAIL cont_count: got %0d want 16", nw); end
      for (int j = 0; j < 16 && j < nw; j++) begin
         checks++;
         if (outq[qb+j] !== exp_word(16, j)) begin errors++; $display("FAIL cont_word[%0d]: got %h want %h", j, outq[qb+j], exp_word(16, j)); end
      end
      rise = (rise_q.size() > rb) ? rise_q[rb] - ab : -1;
      checks++; if (rise != 9) begin errors++; $display("FAIL cont_first_valid: accepts %0d want 9", rise); end
      checks++; if (ce_cnt - cb != 24) begin errors++; $display("FAIL cont_ce: got %0d want 24", ce_cnt - cb); end
      checks++; if (dpr_cnt - db != 1) begin errors++; $display("FAIL cont_dpreset: got %0d want 1", dpr_cnt - db); end
   endtask
   task automatic test_single();
      int qb = outq.size(), cb = ce_cnt, nw;
      samp[0] = DW'(5);
      drive(1, 0, -1, -1, 0);
      nw = outq.size() - qb;
      checks++; if (nw != 8) begin errors++; $display("FAIL single_count: got %0d want 8", nw); end
      for (int j = 0; j < 8 && j < nw; j++) begin
         checks++;
         if (outq[qb+j] !== exp_word(1, j)) begin errors++; $display("FAIL single_word[%0d]: got %h want %h", j, outq[qb+j], exp_word(1, j)); end
      end
      checks++; if (ce_cnt - cb != 16) begin errors++; $display("FAIL single_ce: got %0d want 16", ce_cnt - cb); end
   endtask
   task automatic test_ready_toggle();
      int qb = outq.size(), hb = hold_err, nw;
      for (int i = 0; i < 16; i++) samp[i] = DW'(i);
      drive(16, 1, -1, -1, 0);
      nw = outq.size() - qb;
      checks++; if (nw != 16) begin errors++; $display("FAIL toggle_count: got %0d want 16", nw); end
      for (int j = 0; j < 16 && j < nw; j++) begin
         checks++;
         if (outq[qb+j] !== exp_word(16, j)) begin errors++; $display("FAIL toggle_word[%0d]: got %h want %h", j, outq[qb+j], exp_word(16, j)); end
      end
      checks++; if (hold_err != hb) begin errors++; $display("FAIL toggle_hold: got %0d violations want 0", hold_err - hb); end
   endtask
   task automatic test_gaps();
      int qb = outq.size(), gb = gap_err, nw;
      for (int i = 0; i < 16; i++) samp[i] = DW'(i);
      drive(16, 0, 2, 11, 0);
      nw = outq.size() - qb;
      checks++; if (nw != 16) begin errors++; $display("FAIL gap_count: got %0d want 16", nw); end
      for (int j = 0; j < 16 && j < nw; j++) begin
         checks++;
         if (outq[qb+j] !== exp_word(16, j)) begin errors++; $display("FAIL gap_word[%0d]: got %h want %h", j, outq[qb+j], exp_word(16, j)); end
      end
      checks++; if (gap_err != gb) begin errors++; $display("FAIL gap_ce: got %0d ce in gaps want 0", gap_err - gb); end
   endtask
   task automatic test_midreset();
      int qb, nw;
      for (int i = 0; i < 16; i++) samp[i] = DW'(i);
      drive(16, 0, -1, -1, 12);
      i_reset = 1'b1; i_valid = 1'b1; i_data = DW'($urandom);
      @(negedge clk);
      checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b want 0", o_valid); end
      checks++; if (o_dp_reset !== 1'b1) begin errors++; $display("FAIL mid_dpreset: got %b want 1", o_dp_reset); end
      checks++; if (o_dp_ce !== 1'b0 || o_ready !== 1'b0) begin errors++; $display("FAIL mid_ce_ready: got %b/%b want 0/0", o_dp_ce, o_ready); end
      @(posedge clk);
      #1;
      i_reset = 1'b0; i_valid = 1'b0;
      #1;
      checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b want 0", o_busy); end
      qb = outq.size();
      repeat (10) @(posedge clk);
      #1;
      checks++; if (outq.size() != qb) begin errors++; $display("FAIL mid_leak: got %0d words want 0", outq.size() - qb); end
      qb = outq.size();
      for (int i = 0; i < 8; i++) samp[i] = DW'(i);
      drive(8, 0, -1, -1, 0);
      nw = outq.size() - qb;
      checks++; if (nw != 8) begin errors++; $display("FAIL mid_count: got %0d want 8", nw); end
      for (int j = 0; j < 8 && j < nw; j++) begin
         checks++;
         if (outq[qb+j] !== exp_word(8, j)) begin errors++; $display("FAIL mid_word[%0d]: got %h want %h", j, outq[qb+j], exp_word(8, j)); end
      end
   endtask
   task automatic test_random();
      for (int t = 0; t < 8; t++) begin
         int n = $urandom_range(1, 24);
         int qb = outq.size(), cb = ce_cnt, hb = hold_err, nw, nf;
         nf = (n + N - 1) / N;
         for (int i = 0; i < n; i++) samp[i] = DW'($urandom);
         drive(n, 2, $urandom_range(0, n), $urandom_range(0, n), 0);
         nw = outq.size() - qb;
         checks++; if (nw != nf * N) begin errors++; $display("FAIL rand%0d_count: got %0d want %0d", t, nw, nf * N); end
         for (int j = 0; j < nf * N && j < nw; j++) begin
            checks++;
            if (outq[qb+j] !== exp_word(n, j)) begin errors++; $display("FAIL rand%0d_word[%0d]: got %h want %h", t, j, outq[qb+j], exp_word(n, j)); end
         end
         checks++; if (ce_cnt - cb != nf * N + N) begin errors++; $display("FAIL rand%0d_ce: got %0d want %0d", t, ce_cnt - cb, nf * N + N); end
         checks++; if (hold_err != hb) begin errors++; $display("FAIL rand%0d_hold: got %0d violations want 0", t, hold_err - hb); end
      end
   endtask
   initial begin
      test_reset();
      test_continuous();
      test_single();
      test_ready_toggle();
      test_gaps();
      test_midreset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
